bus_timer: RTL

//  Bus responder on the 65C02 CPU bus: decodes an 8-byte register window, returns

---
 rtl/bus_timer_if.sv | 31 +++
 rtl/bus_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bus_timer_if.sv
// CPU-side bus bundle for bus_timer: address, write data/enable in; read data, ready
// and interrupt out.
interface bus_timer_if;
   logic [15:0] AB;
   logic [7:0]  DI;
   logic        WE;
   logic [7:0]  DO;
   logic        DOV;
   logic        RDY;
   logic        IRQ;

   modport slave (
      input  AB,
      input  DI,
      input  WE,
      output DO,
      output DOV,
      output RDY,
      output IRQ
   );

   modport master (
      output AB,
      output DI,
      output WE,
      input  DO,
      input  DOV,
      input  RDY,
      input  IRQ
   );
endinterface

// File: rtl/bus_timer.sv
// 65C02 bus responder: 8-byte register window with programmable wait states and a
// 16-bit down-counting timer with level interrupt.
module bus_timer #(
   parameter logic [15:0] BASE = 16'hFE00,
   parameter int unsigned WAIT = 1,
   parameter logic [7:0]  ID   = 8'h65
) (
   input logic        clk,
   input logic        RST,
   bus_timer_if.slave bus
);

   localparam logic [3:0] WaitCycles = 4'(WAIT);
   localparam bit         HasWait    = (WAIT != 0);

   typedef enum logic {StIdle, StWaiting} state_e;

   state_e      state_q;
   logic [3:0]  wcnt_q;

   logic        sel;
   logic        rdy;
   logic        commit;
   logic        wr;
   logic        rd;
   logic [2:0]  addr;

   logic        en_q, en_d;
   logic        reload_q, reload_d;
   logic        ien_q, ien_d;
   logic        exp_q, exp_d;
   logic [15:0] load_q, load_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  snap_q, snap_d;
   logic [7:0]  scratch_q, scratch_d;
   logic [7:0]  do_q, do_d;
   logic        dov_q, dov_d;
   logic [7:0]  rdata;
   logic        expire;

   assign addr   = bus.AB[2:0];
   assign sel    = (bus.AB[15:3] == BASE[15:3]);
   assign commit = sel & rdy;
   assign wr     = commit & bus.WE;
   assign rd     = commit & ~bus.WE;
   assign expire = en_q & (cnt_q == 16'd0);

   // RDY only ever drops while this window is addressed.
   always_comb begin
      rdy = 1'b1;
      unique case (state_q)
         StIdle:    rdy = ~(sel & HasWait);
         StWaiting: rdy = ~sel | (wcnt_q == 4'd0);
         default:   rdy = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= StIdle;
         wcnt_q  <= 4'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sel && HasWait) begin
                  wcnt_q  <= WaitCycles - 4'd1;
                  state_q <= StWaiting;
               end
            end
            StWaiting: begin
               if (!sel || wcnt_q == 4'd0) begin
                  state_q <= StIdle;
               end else begin
                  wcnt_q <= wcnt_q - 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      rdata = 8'h00;
      case (addr)
         3'd0:    rdata = {5'b0, ien_q, reload_q, en_q};
         3'd1:    rdata = {7'b0, exp_q};
         3'd2:    rdata = load_q[7:0];
         3'd3:    rdata = load_q[15:8];
         3'd4:    rdata = cnt_q[7:0];
         3'd5:    rdata = snap_q;
         3'd6:    rdata = scratch_q;
         default: rdata = ID;
      endcase
   end

   // Priority order: timer step, then CPU writes override, then expiry sets EXP last.
   always_comb begin
      en_d      = en_q;
      reload_d  = reload_q;
      ien_d     = ien_q;
      exp_d     = exp_q;
      load_d    = load_q;
      cnt_d     = cnt_q;
      snap_d    = snap_q;
      scratch_d = scratch_q;
      do_d      = do_q;
      dov_d     = rd;

      if (en_q) begin
         if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
         end else if (reload_q) begin
            cnt_d = load_q;
         end else begin
            en_d = 1'b0;
         end
      end

      if (wr) begin
         case (addr)
            3'd0: {ien_d, reload_d, en_d} = bus.DI[2:0];
            3'd1: begin
               if (bus.DI[0]) exp_d = 1'b0;
            end
            3'd2: load_d[7:0] = bus.DI;
            3'd3: begin
               load_d[15:8] = bus.DI;
               cnt_d        = {bus.DI, load_q[7:0]};
            end
            3'd6: scratch_d = bus.DI;
            default: ;
         endcase
      end

      if (expire) exp_d = 1'b1;

      if (rd) begin
         do_d = rdata;
         if (addr == 3'd4) snap_d = cnt_q[15:8];
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         en_q      <= 1'b0;
         reload_q  <= 1'b0;
         ien_q     <= 1'b0;
         exp_q     <= 1'b0;
         load_q    <= 16'd0;
         cnt_q     <= 16'd0;
         snap_q    <= 8'd0;
         scratch_q <= 8'd0;
         do_q      <= 8'd0;
         dov_q     <= 1'b0;
      end else begin
         en_q      <= en_d;
         reload_q  <= reload_d;
         ien_q     <= ien_d;
         exp_q     <= exp_d;
         load_q    <= load_d;
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         scratch_q <= scratch_d;
         do_q      <= do_d;
         dov_q     <= dov_d;
      end
   end

   assign bus.RDY = rdy;
   assign bus.DO  = do_q;
   assign bus.DOV = dov_q;
   assign bus.IRQ = exp_q & ien_q;

endmodule
